// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: fetch, load/store and byte-wide
// RAM port bundle around the memory controller.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_done_o;
  logic [31:0]       if_data_o;
  logic              mem_r_req_i;
  logic              mem_w_req_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [31:0]       mem_w_data_i;
  logic [3:0]        mem_buffer_pointer_i;
  logic              mem_done_o;
  logic [31:0]       mem_r_data_o;
  logic [7:0]        ram_din_i;
  logic [7:0]        ram_dout_o;
  logic [ADDR_W-1:0] ram_a_o;
  logic              ram_wr_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  mem_r_req_i, mem_w_req_i,
    input  mem_addr_i, mem_w_data_i,
    input  mem_buffer_pointer_i,
    input  ram_din_i,
    output if_done_o, if_data_o,
    output mem_done_o, mem_r_data_o,
    output ram_dout_o, ram_a_o, ram_wr_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output mem_r_req_i, mem_w_req_i,
    output mem_addr_i, mem_w_data_i,
    output mem_buffer_pointer_i,
    output ram_din_i,
    input  if_done_o, if_data_o,
    input  mem_done_o, mem_r_data_o,
    input  ram_dout_o, ram_a_o, ram_wr_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: sequences fetch and load/store requests
// into per-byte RAM accesses, MEM ahead of IF.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, READ, WRITE, DONE
  } state_t;

  state_t            state;
  logic              owner_mem;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [2:0]        n;
  logic [2:0]        cnt;
  logic [23:0]       asm_buf;

  logic [2:0]  nxt;
  logic [2:0]  req_n;
  logic [31:0] wsh;
  logic        abort;
  logic        grant;
  logic        unused_ptr;

  assign unused_ptr = ^bus.mem_buffer_pointer_i[3:2];

  // Next byte index, store width, abort detect.
  always_comb begin
    nxt   = cnt + 3'd1;
    req_n = 3'd4 -
      {1'b0, bus.mem_buffer_pointer_i[1:0]};
    wsh   = wdata >> {nxt[1:0], 3'b000};
    grant = bus.mem_w_req_i | bus.mem_r_req_i
          | bus.if_req_i;
    abort = (state == READ) && !owner_mem &&
      (!bus.if_req_i || bus.if_addr_i != addr);
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      owner_mem        <= 1'b0;
      addr             <= '0;
      wdata            <= '0;
      n                <= '0;
      cnt              <= '0;
      asm_buf          <= '0;
      bus.if_done_o    <= 1'b0;
      bus.mem_done_o   <= 1'b0;
      bus.if_data_o    <= '0;
      bus.mem_r_data_o <= '0;
      bus.ram_a_o      <= '0;
      bus.ram_dout_o   <= '0;
      bus.ram_wr_o     <= 1'b0;
    end else begin
      bus.if_done_o  <= 1'b0;
      bus.mem_done_o <= 1'b0;
      bus.ram_a_o    <= '0;
      bus.ram_dout_o <= '0;
      bus.ram_wr_o   <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (grant) begin
            wdata <= bus.mem_w_data_i;
            n     <= req_n;
          end
          if (bus.mem_w_req_i) begin
            state          <= WRITE;
            owner_mem      <= 1'b1;
            addr           <= bus.mem_addr_i;
            bus.ram_a_o    <= bus.mem_addr_i;
            bus.ram_dout_o <= bus.mem_w_data_i[7:0];
            bus.ram_wr_o   <= 1'b1;
          end else if (bus.mem_r_req_i) begin
            state       <= READ;
            owner_mem   <= 1'b1;
            addr        <= bus.mem_addr_i;
            bus.ram_a_o <= bus.mem_addr_i;
          end else if (bus.if_req_i) begin
            state       <= READ;
            owner_mem   <= 1'b0;
            addr        <= bus.if_addr_i;
            bus.ram_a_o <= bus.if_addr_i;
          end
        end
        READ: begin
          if (abort) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= nxt;
            case (cnt)
              3'd1: asm_buf[7:0]   <= bus.ram_din_i;
              3'd2: asm_buf[15:8]  <= bus.ram_din_i;
              3'd3: asm_buf[23:16] <= bus.ram_din_i;
              default: ;
            endcase
            if (cnt < 3'd3)
              bus.ram_a_o <= addr + ADDR_W'(nxt);
            if (cnt == 3'd4) begin
              state <= DONE;
              if (owner_mem) begin
                bus.mem_r_data_o <=
                  {bus.ram_din_i, asm_buf};
                bus.mem_done_o <= 1'b1;
              end else begin
                bus.if_data_o <=
                  {bus.ram_din_i, asm_buf};
                bus.if_done_o <= 1'b1;
              end
            end
          end
        end
        WRITE: begin
          cnt <= nxt;
          if (nxt < n) begin
            bus.ram_a_o    <= addr + ADDR_W'(nxt);
            bus.ram_dout_o <= wsh[7:0];
            bus.ram_wr_o   <= 1'b1;
          end else begin
            state          <= DONE;
            bus.mem_done_o <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed stimulus with a scoreboard
// of expected RAM writes and done pulses.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   c;

  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_W(32)) bus();

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        is_mem;
    logic [31:0] data;
    int          cyc;
  } done_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  done_t exp_done[$];
  wr_t   exp_wr[$];
  done_t de;
  wr_t   we;

  logic [7:0] ram [0:4095];

  // Cycle counter for done-pulse timing.
  always @(posedge clk) cyc <= cyc + 1;

  // Byte RAM: read data one cycle after address.
  always @(posedge clk) begin
    if (bus.ram_wr_o)
      ram[bus.ram_a_o[11:0]] <= bus.ram_dout_o;
    bus.ram_din_i <= ram[bus.ram_a_o[11:0]];
  end

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(string tag);
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.if_done_o || bus.mem_done_o) break;
    end
    n_assert++;
    assert (k < 20) else begin
      n_fail++;
      $error("FAIL %s observed=timeout expected=done",
             tag);
    end
  endtask

  task automatic push_wr(logic [31:0] a,
                         logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_wr.push_back(w);
  endtask

  task automatic push_done(logic m,
                           logic [31:0] d,
                           int t);
    done_t e;
    e.is_mem = m;
    e.data = d;
    e.cyc = t;
    exp_done.push_back(e);
  endtask

  task automatic chk_idle_outs(string tag);
    chk({tag, "_if_done"}, 32'(bus.if_done_o), 0);
    chk({tag, "_mem_done"}, 32'(bus.mem_done_o), 0);
    chk({tag, "_ram_a"}, bus.ram_a_o, 0);
    chk({tag, "_ram_dout"}, 32'(bus.ram_dout_o), 0);
    chk({tag, "_ram_wr"}, 32'(bus.ram_wr_o), 0);
  endtask

  // Scoreboard: pop and compare on writes/dones.
  always @(negedge clk) begin
    if (bus.ram_wr_o) begin
      n_assert++;
      assert (exp_wr.size() > 0) else begin
        n_fail++;
        $error("FAIL unexp_write observed=%h expected=none",
               bus.ram_a_o);
      end
      if (exp_wr.size() > 0) begin
        we = exp_wr.pop_front();
        chk("wr_addr", bus.ram_a_o, we.a);
        chk("wr_data", 32'(bus.ram_dout_o), 32'(we.d));
      end
    end
    if (bus.if_done_o || bus.mem_done_o) begin
      chk("done_onehot",
          32'(bus.if_done_o & bus.mem_done_o), 0);
      n_assert++;
      assert (exp_done.size() > 0) else begin
        n_fail++;
        $error("FAIL unexp_done observed=%b%b expected=none",
               bus.if_done_o, bus.mem_done_o);
      end
      if (exp_done.size() > 0) begin
        de = exp_done.pop_front();
        chk("done_port", 32'(bus.mem_done_o),
            32'(de.is_mem));
        chk("done_cycle", cyc, de.cyc);
        if (de.is_mem)
          chk("mem_r_data", bus.mem_r_data_o, de.data);
        else
          chk("if_data", bus.if_data_o, de.data);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.if_req_i = 1'b0;
    bus.if_addr_i = '0;
    bus.mem_r_req_i = 1'b0;
    bus.mem_w_req_i = 1'b0;
    bus.mem_addr_i = '0;
    bus.mem_w_data_i = '0;
    bus.mem_buffer_pointer_i = '0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h11; ram[12'h101] = 8'h22;
    ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
    ram[12'h040] = 8'h78; ram[12'h041] = 8'h56;
    ram[12'h042] = 8'h34; ram[12'h043] = 8'h12;
    ram[12'hFFE] = 8'hA1; ram[12'hFFF] = 8'hB2;
    ram[12'h000] = 8'hC3; ram[12'h001] = 8'hD4;
    ram[12'h221] = 8'h5A;
    ram[12'h302] = 8'hEE; ram[12'h303] = 8'hEE;

    repeat (3) tick();
    @(negedge clk);
    chk_idle_outs("rst");
    chk("rst_if_data", bus.if_data_o, 0);
    chk("rst_mem_data", bus.mem_r_data_o, 0);
    tick();
    rst = 1'b0;
    tick();

    // load word at 0x100
    tick();
    c = cyc;
    bus.mem_addr_i = 32'h100;
    bus.mem_r_req_i = 1'b1;
    push_done(1'b1, 32'h44332211, c + 6);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lw_ram_a", bus.ram_a_o, 32'h100 + k);
      chk("lw_ram_wr", 32'(bus.ram_wr_o), 0);
    end
    @(negedge clk);
    chk("lw_ram_a_off", bus.ram_a_o, 0);
    wait_done("lw_done");
    bus.mem_r_req_i = 1'b0;

    // store word
    tick();
    c = cyc;
    bus.mem_addr_i = 32'h200;
    bus.mem_w_data_i = 32'hDEADBEEF;
    bus.mem_buffer_pointer_i = 4'd0;
    bus.mem_w_req_i = 1'b1;
    push_wr(32'h200, 8'hEF); push_wr(32'h201, 8'hBE);
    push_wr(32'h202, 8'hAD); push_wr(32'h203, 8'hDE);
    push_done(1'b1, 32'h44332211, c + 5);
    wait_done("sw_done");
    bus.mem_w_req_i = 1'b0;

    // store half
    tick();
    c = cyc;
    bus.mem_addr_i = 32'h210;
    bus.mem_w_data_i = 32'hCAFE1234;
    bus.mem_buffer_pointer_i = 4'd2;
    bus.mem_w_req_i = 1'b1;
    push_wr(32'h210, 8'h34); push_wr(32'h211, 8'h12);
    push_done(1'b1, 32'h44332211, c + 3);
    wait_done("sh_done");
    bus.mem_w_req_i = 1'b0;

    // store byte
    tick();
    c = cyc;
    bus.mem_addr_i = 32'h220;
    bus.mem_w_data_i = 32'h998877AB;
    bus.mem_buffer_pointer_i = 4'd3;
    bus.mem_w_req_i = 1'b1;
    push_wr(32'h220, 8'hAB);
    push_done(1'b1, 32'h44332211, c + 2);
    wait_done("sb_done");
    bus.mem_w_req_i = 1'b0;

    // three-byte store, upper ptr bits ignored
    tick();
    c = cyc;
    bus.mem_addr_i = 32'h230;
    bus.mem_w_data_i = 32'h77CCBBAA;
    bus.mem_buffer_pointer_i = 4'b1101;
    bus.mem_w_req_i = 1'b1;
    push_wr(32'h230, 8'hAA); push_wr(32'h231, 8'hBB);
    push_wr(32'h232, 8'hCC);
    push_done(1'b1, 32'h44332211, c + 4);
    wait_done("s3_done");
    bus.mem_w_req_i = 1'b0;
    chk("sb_neighbour", 32'(ram[12'h221]), 32'h5A);

    // arbitration: MEM first, IF right after
    tick();
    c = cyc;
    bus.if_addr_i = 32'h40;
    bus.if_req_i = 1'b1;
    bus.mem_addr_i = 32'h200;
    bus.mem_r_req_i = 1'b1;
    push_done(1'b1, 32'hDEADBEEF, c + 6);
    push_done(1'b0, 32'h12345678, c + 13);
    wait_done("arb_mem_done");
    bus.mem_r_req_i = 1'b0;
    wait_done("arb_if_done");
    bus.if_req_i = 1'b0;

    // fetch abort by address change
    tick();
    c = cyc;
    bus.if_addr_i = 32'h0;
    bus.if_req_i = 1'b1;
    tick();
    tick();
    tick();
    bus.if_addr_i = 32'h40;
    push_done(1'b0, 32'h12345678, c + 10);
    wait_done("abort_refetch");
    bus.if_req_i = 1'b0;

    // address wrap
    tick();
    c = cyc;
    bus.mem_addr_i = 32'hFFFFFFFE;
    bus.mem_r_req_i = 1'b1;
    push_done(1'b1, 32'hD4C3B2A1, c + 6);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("wrap_ram_a", bus.ram_a_o,
          32'hFFFFFFFE + 32'(k));
    end
    wait_done("wrap_done");
    bus.mem_r_req_i = 1'b0;

    // reset after two bytes of a word store
    tick();
    bus.mem_addr_i = 32'h300;
    bus.mem_w_data_i = 32'h11223344;
    bus.mem_buffer_pointer_i = 4'd0;
    bus.mem_w_req_i = 1'b1;
    push_wr(32'h300, 8'h44); push_wr(32'h301, 8'h33);
    tick();
    tick();
    rst = 1'b1;
    bus.mem_w_req_i = 1'b0;
    tick();
    @(negedge clk);
    chk_idle_outs("midrst");
    chk("midrst_mem_data", bus.mem_r_data_o, 0);
    tick();
    rst = 1'b0;
    repeat (8) tick();
    chk("midrst_b0", 32'(ram[12'h300]), 32'h44);
    chk("midrst_b1", 32'(ram[12'h301]), 32'h33);
    chk("midrst_b2", 32'(ram[12'h302]), 32'hEE);
    chk("midrst_b3", 32'(ram[12'h303]), 32'hEE);

    chk("wr_q_left", 32'(exp_wr.size()), 0);
    chk("done_q_left", 32'(exp_done.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the pipeline and the byte-wide RAM port. Serves two requestors: instruction fetch (IF) and the MEM stage's load/store port (read/write request, address, write data, byte pointer, done/read-data return). Each request is sequenced into per-byte RAM accesses, and the controller returns a one-cycle done pulse. MEM has priority over IF.

## Interface
Parameters:
- ADDR_W, 32, address width for requestor and RAM addresses.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req_i  in  1  fetch request, level, held until if_done_o.
- if_addr_i  in  32  fetch address.
- if_done_o  out  1  one-cycle pulse, fetch complete.
- if_data_o  out  32  fetched word, little-endian.
- mem_r_req_i  in  1  load request, level.
- mem_w_req_i  in  1  store request, level. Never asserted together with mem_r_req_i.
- mem_addr_i  in  32  load/store byte address.
- mem_w_data_i  in  32  store data, byte k = bits [8k+7:8k].
- mem_buffer_pointer_i  in  4  store width code. Byte count n = 4 - ptr[1:0] (0→4, 2→2, 3→1, 1→3).
- mem_done_o  out  1  one-cycle pulse, load/store complete.
- mem_r_data_o  out  32  loaded word, always 4 bytes. MEM stage truncates/extends.
- ram_din_i  in  8  RAM read byte, valid one cycle after its address.
- ram_dout_o  out  8  RAM write byte.
- ram_a_o  out  32  RAM byte address.
- ram_wr_o  out  1  1 = write ram_dout_o to ram_a_o at this edge.

## Operation
- States: IDLE, READ, WRITE, DONE. Internal regs:
  - owner: IF or MEM.
  - latched addr, wdata, byte count n.
  - byte counter cnt[2:0].
  - 32-bit assembly buffer.
- IDLE arbitration:
  - mem_w_req_i → WRITE, owner MEM.
  - else mem_r_req_i → READ, owner MEM.
  - else if_req_i → READ, owner IF.
  - Latch addr, wdata and n; cnt=0.
- READ (5 cycles):
  - Cycles k=0..3: ram_a_o = addr+k, ram_wr_o=0.
  - Cycles k=1..4: buffer byte k-1 ← ram_din_i.
  - After cycle k=4: load buffer into if_data_o or mem_r_data_o per owner; go to DONE.
- WRITE (n cycles):
  - Cycle k: ram_a_o = addr+k, ram_dout_o = wdata byte k, ram_wr_o=1.
  - After cycle n-1: go to DONE.
- DONE (1 cycle): the owner's done output is 1, then return to IDLE.
  - The requestor advances on this pulse. IDLE re-samples the request lines on the next cycle, so the same request is never served twice.
- Fetch abort: during an IF-owned READ, if if_req_i=0 or if_addr_i ≠ latched addr:
  - Return to IDLE next cycle.
  - No done pulse; if_data_o unchanged.
- MEM transactions never abort.
- A MEM request arriving during an IF transaction waits for DONE/abort, then wins the next IDLE.
- Address arithmetic addr+k is modulo 2^32 and wraps at 0xFFFFFFFF.

## Timing
- Request sampled in IDLE cycle t.
- Load or fetch: done pulse at cycle t+6. Data output valid from t+6 and held until the next completed read of that port.
- Store: done pulse at cycle t+n+1, i.e. SW t+5, SH t+3, SB t+2.
- Back-to-back requests: next grant no earlier than t_done+1.
- Idle and non-access cycles drive ram_a_o=0, ram_dout_o=0, ram_wr_o=0.
- Reset values:
  - State IDLE.
  - if_done_o=0, mem_done_o=0.
  - if_data_o=0, mem_r_data_o=0.
  - ram_a_o=0, ram_dout_o=0, ram_wr_o=0.
  - All internal regs zero.
- Reset mid-transaction: IDLE on the next edge, no done pulse. Bytes already written stay in RAM; the remaining bytes are not written.
- Only one done output is high in any cycle.

## Test plan
- Load word: RAM[0x100..0x103]=11,22,33,44 and mem_r_req_i at 0x100 → ram_a_o 0x100..0x103 over 4 cycles. At t+6: mem_done_o pulse, mem_r_data_o=0x44332211.
- Store widths: SW 0xDEADBEEF at 0x200 with ptr 0 → 4 writes EF,BE,AD,DE, done at t+5. SH 0x1234 at 0x210 with ptr 2 → 2 writes, done at t+3. SB 0xAB at 0x220 with ptr 3 → 1 write, done at t+2; RAM[0x221] untouched.
- Arbitration: if_req_i and mem_r_req_i rise the same cycle → MEM served first. IF is granted the cycle after mem_done_o and gets if_done_o 6 cycles later.
- Fetch abort: change if_addr_i from 0x0 to 0x40 mid-READ → no if_done_o for 0x0. A new fetch of 0x40 completes with the correct word.
- Wrap: load at 0xFFFFFFFE → addresses FFFFFFFE, FFFFFFFF, 0, 1.
- Reset mid-SW after 2 bytes → only 2 bytes written, all outputs 0 next cycle, no done pulse.
